// File: rtl/psum_accum_seq.sv
// Reads per-kernel-position partial sums from PMEM, streams them into the SFU for accumulation and ReLU, then writes each output pixel back.
// Optional macro PSUM_RD_PIPE_EN registers pmem_q before the SFU, so the read latency becomes 2 cycles.
module psum_accum_seq #(
    parameter int unsigned psum_bw = 16,
    parameter int unsigned col     = 8,
    parameter int unsigned addr_bw = 11,
    parameter int unsigned kpos_bw = 4,
    parameter int unsigned opix_bw = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic [kpos_bw-1:0]       i_n_kpos,
    input  logic [opix_bw-1:0]       i_n_opix,
    input  logic [addr_bw-1:0]       i_psum_base,
    input  logic [addr_bw-1:0]       i_out_base,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_pmem_cen,
    output logic                     o_pmem_wen,
    output logic [addr_bw-1:0]       o_pmem_addr,
    output logic [psum_bw*col-1:0]   o_pmem_d,
    input  logic [psum_bw*col-1:0]   i_pmem_q,
    output logic                     o_sfu_acc,
    output logic [psum_bw*col-1:0]   o_sfu_psum,
    input  logic [psum_bw*col-1:0]   i_sfu_out
);

    localparam int unsigned DW       = psum_bw * col;
    localparam int unsigned WCNT_BW  = 2;
`ifdef PSUM_RD_PIPE_EN
    localparam int unsigned RL = 2;
`else
    localparam int unsigned RL = 1;
`endif

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_FIN} state_t;

    state_t               r_state, w_nstate;
    logic [kpos_bw-1:0]   r_k, w_k, r_n_kpos;
    logic [opix_bw-1:0]   r_p, w_p, r_n_opix;
    logic [WCNT_BW-1:0]   r_wcnt, w_wcnt;
    logic [addr_bw-1:0]   r_raddr, w_raddr, r_pix_base, w_pix_base, r_out_base;
    logic [addr_bw-1:0]   r_addr, w_addr;
    logic                 r_busy, w_busy, r_done, w_done, r_cen, w_cen, r_wen, w_wen;
    logic                 w_load, w_k_last;
    logic [addr_bw-1:0]   w_opix_ext;
    logic                 r_vld, r_last;
    logic                 w_out_vld, w_out_last;
    logic [DW-1:0]        w_out_data;

    assign w_k_last   = (r_k == r_n_kpos - kpos_bw'(1));
    assign w_opix_ext = addr_bw'(r_n_opix);

    // Next state plus the PMEM/handshake values that will be registered for the next cycle.
    always_comb begin
        w_nstate   = r_state;
        w_k        = r_k;
        w_p        = r_p;
        w_wcnt     = r_wcnt;
        w_raddr    = r_raddr;
        w_pix_base = r_pix_base;
        w_addr     = r_addr;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_cen      = 1'b1;
        w_wen      = 1'b1;
        w_load     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_load = 1'b1;
                    if (i_n_kpos == '0 || i_n_opix == '0) begin
                        w_nstate = S_FIN;
                        w_done   = 1'b1;
                    end else begin
                        w_nstate   = S_RD;
                        w_busy     = 1'b1;
                        w_cen      = 1'b0;
                        w_addr     = i_psum_base;
                        w_k        = '0;
                        w_p        = '0;
                        w_pix_base = i_psum_base;
                        w_raddr    = i_psum_base + addr_bw'(i_n_opix);
                    end
                end
            end
            S_RD: begin
                w_busy = 1'b1;
                if (w_k_last) begin
                    w_nstate = S_WAIT;
                    w_wcnt   = '0;
                end else begin
                    w_k     = r_k + kpos_bw'(1);
                    w_cen   = 1'b0;
                    w_addr  = r_raddr;
                    w_raddr = r_raddr + w_opix_ext;
                end
            end
            S_WAIT: begin
                w_busy = 1'b1;
                if (r_wcnt == WCNT_BW'(RL - 1)) begin
                    w_nstate = S_WR;
                    w_cen    = 1'b0;
                    w_wen    = 1'b0;
                    w_addr   = r_out_base + addr_bw'(r_p);
                end else begin
                    w_wcnt = r_wcnt + WCNT_BW'(1);
                end
            end
            S_WR: begin
                w_p = r_p + opix_bw'(1);
                if (r_p == r_n_opix - opix_bw'(1)) begin
                    w_nstate = S_FIN;
                    w_done   = 1'b1;
                end else begin
                    w_nstate   = S_RD;
                    w_busy     = 1'b1;
                    w_cen      = 1'b0;
                    w_k        = '0;
                    w_pix_base = r_pix_base + addr_bw'(1);
                    w_addr     = r_pix_base + addr_bw'(1);
                    w_raddr    = r_pix_base + addr_bw'(1) + w_opix_ext;
                end
            end
            S_FIN:   w_nstate = S_IDLE;
            default: w_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_p        <= '0;
            r_wcnt     <= '0;
            r_raddr    <= '0;
            r_pix_base <= '0;
            r_addr     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cen      <= 1'b1;
            r_wen      <= 1'b1;
            r_n_kpos   <= '0;
            r_n_opix   <= '0;
            r_out_base <= '0;
        end else begin
            r_state    <= w_nstate;
            r_k        <= w_k;
            r_p        <= w_p;
            r_wcnt     <= w_wcnt;
            r_raddr    <= w_raddr;
            r_pix_base <= w_pix_base;
            r_addr     <= w_addr;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_cen      <= w_cen;
            r_wen      <= w_wen;
            if (w_load) begin
                r_n_kpos   <= i_n_kpos;
                r_n_opix   <= i_n_opix;
                r_out_base <= i_out_base;
            end
        end
    end

    // Valid/last flags follow each issued read so they line up with pmem_q.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_vld  <= 1'b0;
            r_last <= 1'b0;
        end else begin
            r_vld  <= (r_state == S_RD);
            r_last <= (r_state == S_RD) && w_k_last;
        end
    end

`ifdef PSUM_RD_PIPE_EN
    logic          r_vld2, r_last2;
    logic [DW-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_vld2  <= 1'b0;
            r_last2 <= 1'b0;
            r_q     <= '0;
        end else begin
            r_vld2  <= r_vld;
            r_last2 <= r_last;
            r_q     <= i_pmem_q;
        end
    end

    assign w_out_vld  = r_vld2;
    assign w_out_last = r_last2;
    assign w_out_data = r_q;
`else
    assign w_out_vld  = r_vld;
    assign w_out_last = r_last;
    assign w_out_data = i_pmem_q;
`endif

    // Idle cycles feed zeros with acc high so the SFU accumulator holds.
    assign o_sfu_psum  = w_out_vld ? w_out_data : '0;
    assign o_sfu_acc   = ~(w_out_vld & w_out_last);
    assign o_pmem_d    = (r_state == S_WR) ? i_sfu_out : '0;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pmem_cen  = r_cen;
    assign o_pmem_wen  = r_wen;
    assign o_pmem_addr = r_addr;

endmodule

// File: tb/tb_psum_accum_seq.sv
// Bench for psum_accum_seq with behavioural PMEM and SFU models; expected outputs come from direct sums of stored psums.
module tb_psum_accum_seq;

`ifdef PSUM_RD_PIPE_EN
    localparam int RL = 2;
`else
    localparam int RL = 1;
`endif
    localparam int DEPTH = 2048;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start;
    logic [3:0]   i_n_kpos;
    logic [7:0]   i_n_opix;
    logic [10:0]  i_psum_base, i_out_base;
    logic         o_busy, o_done, o_pmem_cen, o_pmem_wen, o_sfu_acc;
    logic [10:0]  o_pmem_addr;
    logic [127:0] o_pmem_d, pmem_q, o_sfu_psum, sfu_out;

    logic [127:0] mem  [DEPTH];
    logic [127:0] snap [DEPTH];
    logic signed [15:0] acc_reg [8];

    int n_tests = 0;
    int n_fail  = 0;
    int rdq[$];
    int wrq[$];
    int acc_low;

    always #5 clk = ~clk;

    psum_accum_seq dut (
        .i_clk(clk), .i_reset(rst), .i_start(i_start),
        .i_n_kpos(i_n_kpos), .i_n_opix(i_n_opix),
        .i_psum_base(i_psum_base), .i_out_base(i_out_base),
        .o_busy(o_busy), .o_done(o_done),
        .o_pmem_cen(o_pmem_cen), .o_pmem_wen(o_pmem_wen),
        .o_pmem_addr(o_pmem_addr), .o_pmem_d(o_pmem_d), .i_pmem_q(pmem_q),
        .o_sfu_acc(o_sfu_acc), .o_sfu_psum(o_sfu_psum), .i_sfu_out(sfu_out)
    );

    // Single-port SRAM, read data one cycle after the address.
    always @(posedge clk) begin
        if (!o_pmem_cen) begin
            if (!o_pmem_wen) mem[o_pmem_addr] <= o_pmem_d;
            else             pmem_q <= mem[o_pmem_addr];
        end
    end

    // SFU: accumulate while acc=1; on acc=0 emit ReLU(sum) and clear.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < 8; l++) acc_reg[l] <= '0;
            sfu_out <= '0;
        end else begin
            for (int l = 0; l < 8; l++) begin
                logic signed [15:0] s;
                s = acc_reg[l] + $signed(o_sfu_psum[l*16 +: 16]);
                if (!o_sfu_acc) begin
                    sfu_out[l*16 +: 16] <= (s < 0) ? 16'd0 : s;
                    acc_reg[l] <= '0;
                end else begin
                    acc_reg[l] <= s;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!o_pmem_cen && o_pmem_wen)  rdq.push_back(int'(o_pmem_addr));
        if (!o_pmem_cen && !o_pmem_wen) wrq.push_back(int'(o_pmem_addr));
        if (!o_sfu_acc) acc_low++;
    end

    function automatic logic [127:0] ref_word(input int kpos, input int opix, input int pbase, input int p);
        logic [127:0] w;
        w = '0;
        for (int l = 0; l < 8; l++) begin
            int s;
            s = 0;
            for (int k = 0; k < kpos; k++) begin
                logic [127:0] x;
                x = snap[(pbase + k*opix + p) % DEPTH];
                s += int'($signed(x[l*16 +: 16]));
            end
            if (s < 0) s = 0;
            w[l*16 +: 16] = 16'(s);
        end
        return w;
    endfunction

    task automatic run_job(input int kpos, input int opix, input int pbase, input int obase,
                           input bit extra_start, input string name);
        int cyc, busy_lo, busy_hi, exp_done, bad;
        bit got;
        rdq.delete(); wrq.delete(); acc_low = 0;
        snap = mem;
        @(negedge clk);
        i_n_kpos = 4'(kpos); i_n_opix = 8'(opix);
        i_psum_base = 11'(pbase); i_out_base = 11'(obase);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        cyc = 1; got = 0; busy_lo = 0; busy_hi = 0;
        while (cyc < 3000) begin
            if (o_done) begin got = 1; break; end
            if (o_busy) busy_hi++; else busy_lo++;
            if (extra_start && cyc == 3) begin
                i_start = 1'b1; i_n_kpos = 4'd7; i_n_opix = 8'd9;
                i_psum_base = 11'd77; i_out_base = 11'd88;
            end else begin
                i_start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        i_start = 1'b0;
        exp_done = (kpos == 0 || opix == 0) ? 1 : 1 + opix*(kpos + RL + 1);
        n_tests++;
        if (!got || cyc !== exp_done) begin
            n_fail++; $display("FAIL %s done_cycle got=%0d (seen=%0d) exp=%0d", name, cyc, got, exp_done);
        end
        if (!got) return;
        n_tests++;
        if (o_busy !== 1'b0 || busy_lo !== ((kpos == 0 || opix == 0) ? cyc-1 : 0)) begin
            n_fail++; $display("FAIL %s busy busy_at_done=%0b busy_low_cycles=%0d busy_high_cycles=%0d", name, o_busy, busy_lo, busy_hi);
        end
        @(negedge clk);
        n_tests++;
        if (o_done !== 1'b0) begin
            n_fail++; $display("FAIL %s done_pulse_width done still %0b", name, o_done);
        end
        bad = (rdq.size() != kpos*opix) ? 1 : 0;
        if (!bad)
            for (int p = 0; p < opix; p++)
                for (int k = 0; k < kpos; k++)
                    if (rdq[p*kpos + k] != (pbase + k*opix + p) % DEPTH) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL %s read_addrs got %0d reads (first=%0d) exp %0d reads", name, rdq.size(), (rdq.size() > 0) ? rdq[0] : -1, kpos*opix);
        end
        bad = 0;
        if ((kpos == 0 || opix == 0) ? (wrq.size() != 0) : (wrq.size() != opix)) bad = 1;
        else for (int p = 0; p < wrq.size(); p++) if (wrq[p] != (obase + p) % DEPTH) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL %s write_addrs got %0d writes exp %0d", name, wrq.size(), (kpos == 0) ? 0 : opix);
        end
        n_tests++;
        if (acc_low !== ((kpos == 0) ? 0 : opix)) begin
            n_fail++; $display("FAIL %s acc_low_cycles got=%0d exp=%0d", name, acc_low, (kpos == 0) ? 0 : opix);
        end
        if (kpos > 0) begin
            for (int p = 0; p < opix; p++) begin
                logic [127:0] e;
                e = ref_word(kpos, opix, pbase, p);
                n_tests++;
                if (mem[(obase + p) % DEPTH] !== e) begin
                    n_fail++; $display("FAIL %s result p=%0d got=%h exp=%h", name, p, mem[(obase + p) % DEPTH], e);
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_tests++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_pmem_cen !== 1'b1 || o_pmem_wen !== 1'b1 ||
            o_pmem_addr !== 11'd0 || o_pmem_d !== 128'd0 || o_sfu_acc !== 1'b1 || o_sfu_psum !== 128'd0) begin
            n_fail++;
            $display("FAIL %s reset_outputs busy=%b done=%b cen=%b wen=%b addr=%0d d=%h acc=%b psum=%h (exp 0 0 1 1 0 0 1 0)",
                     name, o_busy, o_done, o_pmem_cen, o_pmem_wen, o_pmem_addr, o_pmem_d, o_sfu_acc, o_sfu_psum);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");
    endtask

    task automatic test_basic();
        for (int a = 0; a < DEPTH; a++) mem[a] = '0;
        mem[0][15:0] = 16'sd5;  mem[0][31:16] = -16'sd10;
        mem[2][15:0] = -16'sd2; mem[2][31:16] = 16'sd3;
        mem[4][15:0] = 16'sd4;  mem[4][31:16] = 16'sd2;
        for (int l = 0; l < 8; l++) begin
            mem[1][l*16 +: 16] = 16'd1; mem[3][l*16 +: 16] = 16'd1; mem[5][l*16 +: 16] = 16'd1;
        end
        run_job(3, 2, 0, 100, 1'b0, "basic");
        n_tests++;
        if (mem[100][15:0] !== 16'd7 || mem[100][31:16] !== 16'd0) begin
            n_fail++; $display("FAIL basic pix0 lane0=%0d lane1=%0d exp 7 0", mem[100][15:0], mem[100][31:16]);
        end
        n_tests++;
        if (mem[101] !== {8{16'd3}}) begin
            n_fail++; $display("FAIL basic pix1 got=%h exp all lanes 3", mem[101]);
        end
    endtask

    task automatic test_kpos1();
        for (int i = 0; i < 4; i++) mem[50 + i] = 128'h5;
        run_job(1, 4, 50, 200, 1'b0, "kpos1");
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (mem[200 + i] !== 128'h5) begin
                n_fail++; $display("FAIL kpos1 out%0d got=%h exp=%h", i, mem[200 + i], 128'h5);
            end
        end
    endtask

    task automatic test_zero();
        run_job(3, 0, 10, 400, 1'b0, "zero_opix");
        run_job(0, 5, 10, 400, 1'b0, "zero_kpos");
    endtask

    task automatic test_reset_mid();
        int guard;
        for (int a = 10; a < 19; a++) mem[a] = {8{16'd2}};
        rdq.delete();
        @(negedge clk);
        i_n_kpos = 4'd3; i_n_opix = 8'd3; i_psum_base = 11'd10; i_out_base = 11'd500;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        guard = 0;
        while (rdq.size() < 4 && guard < 100) begin @(negedge clk); guard++; end
        n_tests++;
        if (guard >= 100) begin
            n_fail++; $display("FAIL reset_mid timeout reads=%0d exp>=4", rdq.size());
        end
        #1 rst = 1'b1;
        #1 check_idle_outputs("reset_mid");
        @(negedge clk);
        rst = 1'b0;
        for (int a = 20; a < 26; a++) mem[a] = {8{16'd4}};
        run_job(2, 3, 20, 600, 1'b0, "after_reset");
    endtask

    task automatic test_wrap_busy_start();
        for (int k = 0; k < 3; k++)
            for (int p = 0; p < 2; p++)
                for (int l = 0; l < 8; l++)
                    mem[(2046 + k*2 + p) % DEPTH][l*16 +: 16] = 16'(k*10 + p + l);
        run_job(3, 2, 2046, 300, 1'b1, "wrap_busy_start");
        n_tests++;
        if (rdq.size() < 3 || rdq[0] != 2046 || rdq[1] != 0 || rdq[2] != 2) begin
            n_fail++; $display("FAIL wrap first_reads got %0d,%0d,%0d exp 2046,0,2",
                               (rdq.size() > 0) ? rdq[0] : -1, (rdq.size() > 1) ? rdq[1] : -1, (rdq.size() > 2) ? rdq[2] : -1);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int kpos, opix, pbase, obase;
            kpos  = int'($urandom_range(8, 1));
            opix  = int'($urandom_range(20, 1));
            pbase = int'($urandom_range(DEPTH - 1));
            obase = (pbase + 1024) % DEPTH;
            for (int a = 0; a < kpos*opix; a++)
                for (int l = 0; l < 8; l++) begin
                    int v;
                    v = int'($urandom_range(2000)) - 1000;
                    mem[(pbase + a) % DEPTH][l*16 +: 16] = 16'(v);
                end
            run_job(kpos, opix, pbase, obase, 1'b0, $sformatf("random%0d", t));
        end
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_n_kpos = '0; i_n_opix = '0;
        i_psum_base = '0; i_out_base = '0; pmem_q = '0;
        for (int a = 0; a < DEPTH; a++) mem[a] = '0;
        test_reset();
        test_basic();
        test_kpos1();
        test_zero();
        test_reset_mid();
        test_wrap_busy_start();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
